// File: rtl/mmix_bus_arbiter.sv
// Round-robin arbiter sharing the MMIX memory bus between instruction fetch (p0)
// and load/store (p1), with a per-access timeout so a lost done cannot hang the core.
module mmix_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] p0_address,
  input  logic [1:0]  p0_datasize,
  input  logic        p0_read,
  input  logic        p0_write,
  input  logic [63:0] p0_writedata,
  output logic [63:0] p0_readdata,
  output logic        p0_done,
  output logic        p0_err,
  input  logic [63:0] p1_address,
  input  logic [1:0]  p1_datasize,
  input  logic        p1_read,
  input  logic        p1_write,
  input  logic [63:0] p1_writedata,
  output logic [63:0] p1_readdata,
  output logic        p1_done,
  output logic        p1_err,
  output logic [63:0] mmix_address,
  output logic [1:0]  mmix_datasize,
  output logic        mmix_read,
  output logic        mmix_write,
  output logic [63:0] mmix_writedata,
  input  logic [63:0] mmix_readdata,
  input  logic        mmix_done,
  output logic        busy,
  output logic        grant,
  output logic        timeout_seen
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, COMPLETE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_last_grant;
  logic          r_grant;
  logic [CW-1:0] r_count;
  logic [63:0]   r_address;
  logic [1:0]    r_datasize;
  logic [63:0]   r_writedata;
  logic          r_read;
  logic          r_write;
  logic          r_done;
  logic          r_err;
  logic [63:0]   r_rdata;
  logic          r_timeout_seen;

  logic w_req0;
  logic w_req1;
  logic w_pick;
  logic w_sel_read;
  logic w_timeout;

  // Under contention the port that did not own the last transaction wins.
  always_comb begin
    w_req0     = p0_read | p0_write;
    w_req1     = p1_read | p1_write;
    w_pick     = w_req1 & (~w_req0 | ~r_last_grant);
    w_sel_read = w_pick ? p1_read : p0_read;
    w_timeout  = (r_count == LAST_COUNT);
    w_next     = r_state;
    case (r_state)
      IDLE:     if (w_req0 | w_req1) w_next = BUSY;
      BUSY:     if (mmix_done | w_timeout) w_next = COMPLETE;
      COMPLETE: w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant   <= 1'b1;
      r_grant        <= 1'b0;
      r_count        <= '0;
      r_address      <= '0;
      r_datasize     <= '0;
      r_writedata    <= '0;
      r_read         <= 1'b0;
      r_write        <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_rdata        <= '0;
      r_timeout_seen <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req0 | w_req1) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_count      <= '0;
            r_address    <= w_pick ? p1_address   : p0_address;
            r_datasize   <= w_pick ? p1_datasize  : p0_datasize;
            r_writedata  <= w_pick ? p1_writedata : p0_writedata;
            // Read takes precedence when a port raises both strobes.
            r_read       <= w_sel_read;
            r_write      <= ~w_sel_read;
          end
        end
        BUSY: begin
          r_count <= r_count + CW'(1);
          if (mmix_done) begin
            r_done  <= 1'b1;
            r_err   <= 1'b0;
            r_rdata <= r_read ? mmix_readdata : '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
          end else if (w_timeout) begin
            r_done         <= 1'b1;
            r_err          <= 1'b1;
            r_rdata        <= '0;
            r_timeout_seen <= 1'b1;
            r_read         <= 1'b0;
            r_write        <= 1'b0;
          end
        end
        COMPLETE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= '0;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign p0_done        = r_done & ~r_grant;
  assign p1_done        = r_done & r_grant;
  assign p0_err         = r_err & ~r_grant;
  assign p1_err         = r_err & r_grant;
  assign p0_readdata    = r_grant ? '0 : r_rdata;
  assign p1_readdata    = r_grant ? r_rdata : '0;
  assign mmix_address   = r_address;
  assign mmix_datasize  = r_datasize;
  assign mmix_read      = r_read;
  assign mmix_write     = r_write;
  assign mmix_writedata = r_writedata;
  assign busy           = (r_state != IDLE);
  assign grant          = r_grant;
  assign timeout_seen   = r_timeout_seen;

endmodule

// File: doc/mmix_bus_arbiter.md
# mmix_bus_arbiter

Two-port arbiter that shares the single MMIX memory bus (address/datasize/read/write/writedata/readdata/done handshake) between the instruction-fetch port (p0) and the load/store port (p1) of the cpu.
- Owns one outstanding transaction at a time and alternates grants round-robin under contention.
- Bounds every access with a timeout, so a missing `mmix_done` cannot hang the core.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: max BUSY cycles without `mmix_done` before the access is aborted (≥2).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pN_address`  in  64  requester N byte address (N = 0, 1).
- `pN_datasize`  in  2  0 byte, 1 wyde, 2 tetra, 3 octa.
- `pN_read`  in  1  read request level; held until `pN_done`.
- `pN_write`  in  1  write request level; held until `pN_done`.
- `pN_writedata`  in  64  write data.
- `pN_readdata`  out  64  read data; valid only while `pN_done`=1.
- `pN_done`  out  1  one-cycle completion pulse.
- `pN_err`  out  1  high with `pN_done` when the access timed out.
- `mmix_address`  out  64  downstream address, registered.
- `mmix_datasize`  out  2  downstream size, registered.
- `mmix_read`  out  1  downstream read strobe, registered.
- `mmix_write`  out  1  downstream write strobe, registered.
- `mmix_writedata`  out  64  downstream write data, registered.
- `mmix_readdata`  in  64  downstream read data, sampled when `mmix_done`=1.
- `mmix_done`  in  1  downstream completion.
- `busy`  out  1  FSM not IDLE.
- `grant`  out  1  owner of the current or last transaction.
- `timeout_seen`  out  1  sticky; set on any timeout, cleared only by reset.

## Operation
- Reset, asynchronous: FSM=IDLE, every output 0, `last_grant`=1 so p0 wins the first tie, timeout counter=0.
- Request: a port is requesting when `read|write`=1; if both are high, read is issued and write is ignored.
- IDLE:
  - One requester: grant it.
  - Both requesting: grant the port ≠ `last_grant`.
  - On grant, register address/datasize/writedata and the strobe, set `grant` and `last_grant`, clear the counter, go to BUSY.
- BUSY:
  - Strobe held constant; counter increments each cycle.
  - If `mmix_done`=1: capture `mmix_readdata` (0 for writes), go to COMPLETE.
  - Else if counter = `TIMEOUT_CYCLES`-1: set `err`, readdata=0, set `timeout_seen`, go to COMPLETE.
- COMPLETE, exactly one cycle:
  - `mmix_read`/`mmix_write`=0.
  - Granted `pN_done`=1 with `pN_readdata`/`pN_err` valid; the other port's outputs stay 0.
  - Go to IDLE.
- `mmix_done` in IDLE or COMPLETE is ignored; a late done after a timeout is never forwarded.
- The requester drops its strobe at the edge ending its done cycle, so IDLE never re-grants a completed request.
- The non-granted request waits with no loss; the new request is evaluated in the next IDLE cycle.
- Reset mid-transaction aborts the access: no done pulse, strobes drop immediately.

## Timing
- Request high in cycle 0 → `mmix_read`/`mmix_write` high in cycle 1.
- `mmix_done` high in cycle k → `pN_done` high in cycle k+1, and downstream strobe low in cycle k+1.
- Zero-wait memory (done one cycle after strobe): request cycle 0, strobe cycles 1–2, done cycle 3; minimum 4 cycles per access including IDLE.
- Back-to-back contention: grants alternate p0, p1, p0, …; minimum one IDLE cycle between transactions.
- Timeout: strobe held for exactly `TIMEOUT_CYCLES` BUSY cycles, then COMPLETE with err.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Single read: p0 read octa at 0x100 and memory returns 0x0123456789ABCDEF with done one cycle after strobe → `mmix_read` cycle 1, `p0_done`=1 with that data in cycle 3, `p0_err`=0.
- Single write: p1 writes tetra 0xDEADBEEF to 0x2000 → `mmix_write`/datasize=2/data match from cycle 1; `p1_done` pulses once and `p1_readdata`=0.
- Contention: p0 and p1 request in the same cycle from reset → p0 served first, then p1; repeated pairs alternate. Neither `done` pulses for the other port.
- Timeout: `TIMEOUT_CYCLES`=8, memory never asserts done → strobe high 8 cycles, then `p0_done`=`p0_err`=1 and `timeout_seen`=1. A late `mmix_done` afterward is ignored.
- Read+write both high on p1 → only `mmix_read` is issued.
- Reset asserted while BUSY → all outputs 0 immediately, no done pulse; after release, a new p1 request completes normally.
